neg_share_arbiter: RTL and testbench
====================================

Name: neg_share_arbiter

Overview:
- Shares one `negative` two's-complement unit between two requesters (port 0, port 1).
- Each request carries an operand and a negate flag.
- Round-robin arbitration selects one request per cycle. The selected operand drives the `negative` instance, with `enable` = negate flag.
- The result is captured in a single output register and delivered over a valid/ready handshake, tagged with the requester id.

Parameters:
- WIDTH, 8, operand/result width in bits. The `negative` instance is 8-bit; WIDTH other than 8 is unsupported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_number  in  WIDTH  requester 0 operand
- req0_negate  in  1  1 = negate operand; 0 = pass through
- req0_ready  out  1  requester 0 request accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has a request
- req1_number  in  WIDTH  requester 1 operand
- req1_negate  in  1  requester 1 negate flag
- req1_ready  out  1  requester 1 accepted this cycle
- out_valid  out  1  output register holds a result
- out_result  out  WIDTH  result
- out_id  out  1  requester that produced out_result
- out_ovf  out  1  negation of most-negative value (10000000) attempted
- out_ready  in  1  consumer takes the result this cycle
- busy_cnt  out  8  total transactions completed; wraps 255 -> 0

Behaviour:
- Reset: asynchronous, active-high. Clears all state immediately, regardless of clock, including mid-transaction; a pending result is discarded.
  - out_valid=0, out_result=0, out_id=0, out_ovf=0, busy_cnt=0, priority pointer=0.
  - req*_ready=0 while reset is high.
- State machine:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- slot_free = (state==EMPTY) | (out_valid & out_ready). Draining and refilling in the same cycle is allowed, so back-to-back throughput is one result per cycle.
- Grant (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester equal to the priority pointer wins.
  - req_ready[g] = slot_free & reqg_valid. The non-granted ready is 0.
  - Ready never depends on the same requester's ready; no combinational loop through out_ready beyond slot_free.
- Accept (req_valid & req_ready at edge N):
  - At N+1: out_valid=1, out_result = negate ? (~number + 1) mod 2^WIDTH : number, out_id = g.
  - out_ovf = negate & (number == 10000000); the result is then 10000000.
  - Priority pointer <= ~g, so the other requester wins the next tie.
  - Latency: 1 cycle.
- Drain (out_valid & out_ready, no accept): EMPTY at next edge; out_result/out_id/out_ovf hold their last values.
- Drain plus accept in the same cycle: stays FULL with the new result loaded.
- Completion counting: busy_cnt increments by 1 on every drain (out_valid & out_ready); 8-bit wrap.
- Hold: FULL & !out_ready keeps out_result/out_id/out_ovf stable; both readies stay 0.
- Requesters must hold valid and operand until ready; the block does not latch unaccepted requests.
- Zero operand with negate gives 0, out_ovf=0.

Test Plan:
- Reset mid-stream:
  - Stimulus: FULL with out_ready=0; assert reset between clock edges.
  - Required: out_valid=0, busy_cnt=0 immediately (no edge needed); after release, pointer=0.
- Single requester:
  - Stimulus: req0 with number=00110110, negate=0, then negate=1.
  - Required: out_result 00110110, then 11001010; out_id=0; each appears one cycle after accept.
- Arithmetic corners via req1 with negate=1:
  - 10110011 -> 01001101.
  - 00000000 -> 00000000.
  - 11111111 -> 00000001.
  - 10000000 -> 10000000 with out_ovf=1.
- Contention:
  - Stimulus: both valid continuously, out_ready=1.
  - Required: grants alternate 0,1,0,1 from reset; one result per cycle; busy_cnt=4 after four drains.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles while both requests are valid.
  - Required: result held stable, req0_ready=req1_ready=0; on out_ready=1, drain and next grant occur in the same cycle.
- Counter wrap:
  - Stimulus: 256 drains.
  - Required: busy_cnt returns to 0.

Source files
------------

// File: rtl/neg_share_arbiter.sv
// neg_share_arbiter
//   Two requesters share one two's-complement `negative` unit. A round-robin
//   grant picks one request per cycle. The selected operand goes through the
//   unit, and the result lands in a single output register tagged with the
//   requester id.
//
// Handshake rule (all ports): a transfer happens on a rising clk edge where
//   valid & ready are both 1. A source holds valid and its payload stable
//   until that edge. Ready may depend on valid. Valid never depends on ready.
//
// Ports
//   clk, reset                 rising-edge clock, async active-high reset
//   req0_valid/number/negate   requester 0 request (in)
//   req0_ready                 requester 0 accepted this cycle (out, comb)
//   req1_valid/number/negate   requester 1 request (in)
//   req1_ready                 requester 1 accepted this cycle (out, comb)
//   out_valid/result/id/ovf    registered result, producing requester, overflow
//   out_ready                  consumer takes the result this cycle (in)
//   busy_cnt                   completed transactions (drains), wraps at 256

module negative #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] number,
    input  logic             enable,
    output logic [WIDTH-1:0] result
);
    assign result = enable ? (~number + WIDTH'(1)) : number;
endmodule

module neg_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_number,
    input  logic             req0_negate,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_number,
    input  logic             req1_negate,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic             out_id,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic [7:0]       busy_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic             prio;       // requester that wins a tie
    logic             slot_free;
    logic             drain;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_number;
    logic             sel_negate;
    logic [WIDTH-1:0] neg_result;

    assign out_valid = (state == FULL);
    assign drain     = out_valid & out_ready;
    // The output register can take a new result when empty or when it is
    // being emptied on this same edge.
    assign slot_free = (state == EMPTY) | drain;

    // Only-one-valid grants that requester; a tie goes to the pointer.
    assign grant = (req0_valid & req1_valid) ? prio : req1_valid;

    // reset gates ready explicitly: the state reads EMPTY during reset, which
    // would otherwise advertise a free slot.
    assign req0_ready = !reset & slot_free & req0_valid & (grant == 1'b0);
    assign req1_ready = !reset & slot_free & req1_valid & (grant == 1'b1);
    assign accept     = req0_ready | req1_ready;

    assign sel_number = grant ? req1_number : req0_number;
    assign sel_negate = grant ? req1_negate : req0_negate;

    negative #(.WIDTH(WIDTH)) u_negative (
        .number (sel_number),
        .enable (sel_negate),
        .result (neg_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            prio       <= 1'b0;
            out_result <= '0;
            out_id     <= 1'b0;
            out_ovf    <= 1'b0;
            busy_cnt   <= 8'd0;
        end else begin
            if (drain) begin
                busy_cnt <= busy_cnt + 8'd1;
            end
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    // Drain with refill stays FULL; a bare drain empties.
                    if (out_ready && !accept) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                out_result <= neg_result;
                out_id     <= grant;
                out_ovf    <= sel_negate & (sel_number == MOST_NEG);
                prio       <= ~grant;
            end
        end
    end
endmodule

// File: tb/tb_neg_share_arbiter.sv
// tb_neg_share_arbiter
//   Directed-vector bench for neg_share_arbiter. Inputs change 1 ns after the
//   rising edge; outputs are sampled after that settling time, away from the edge.

module tb_neg_share_arbiter;
    logic       clk;
    logic       reset;
    logic       req0_valid;
    logic [7:0] req0_number;
    logic       req0_negate;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_number;
    logic       req1_negate;
    logic       req1_ready;
    logic       out_valid;
    logic [7:0] out_result;
    logic       out_id;
    logic       out_ovf;
    logic       out_ready;
    logic [7:0] busy_cnt;

    int vectors;
    int miscompares;

    // expected {id, ovf, result}
    logic [9:0] exp_q[$];

    neg_share_arbiter #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_number (req0_number),
        .req0_negate (req0_negate),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_number (req1_number),
        .req1_negate (req1_negate),
        .req1_ready  (req1_ready),
        .out_valid   (out_valid),
        .out_result  (out_result),
        .out_id      (out_id),
        .out_ovf     (out_ovf),
        .out_ready   (out_ready),
        .busy_cnt    (busy_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req0(input logic v, input logic [7:0] n, input logic neg);
        req0_valid  = v;
        req0_number = n;
        req0_negate = neg;
    endtask

    task automatic drive_req1(input logic v, input logic [7:0] n, input logic neg);
        req1_valid  = v;
        req1_number = n;
        req1_negate = neg;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b0;
        drive_req0(1'b1, 8'h12, 1'b0);
        drive_req1(1'b1, 8'h34, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 8'h00 || out_id !== 1'b0 || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out got v=%b r=%h id=%b ovf=%b exp 0 00 0 0", out_valid, out_result, out_id, out_ovf);
        end
        vectors++;
        if (busy_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_busy got %0d exp 0", busy_cnt);
        end
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready);
        end
        drive_req0(1'b0, 8'h00, 1'b0);
        drive_req1(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive_req0(1'b1, 8'h36, 1'b0);
        #1;
        vectors++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ready got %b%b exp 10", req0_ready, req1_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 8'h36 || out_id !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pass got v=%b r=%h id=%b exp 1 36 0", out_valid, out_result, out_id);
        end
        drive_req0(1'b1, 8'h36, 1'b1);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 8'hCA || out_id !== 1'b0 || out_ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL single_neg got v=%b r=%h id=%b ovf=%b exp 1 ca 0 0", out_valid, out_result, out_id, out_ovf);
        end
        drive_req0(1'b0, 8'h00, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_result !== 8'hCA || busy_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL single_drain got v=%b r=%h busy=%0d exp 0 ca 2", out_valid, out_result, busy_cnt);
        end
    endtask

    task automatic test_corners();
        logic [7:0] ins [4];
        logic [7:0] exps[4];
        logic       ovfs[4];
        ins[0] = 8'hB3; exps[0] = 8'h4D; ovfs[0] = 1'b0;
        ins[1] = 8'h00; exps[1] = 8'h00; ovfs[1] = 1'b0;
        ins[2] = 8'hFF; exps[2] = 8'h01; ovfs[2] = 1'b0;
        ins[3] = 8'h80; exps[3] = 8'h80; ovfs[3] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req1(1'b1, ins[i], 1'b1);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_result !== exps[i] || out_id !== 1'b1 || out_ovf !== ovfs[i]) begin
                miscompares++;
                $display("FAIL corner_%0d in=%h got v=%b r=%h id=%b ovf=%b exp 1 %h 1 %b",
                         i, ins[i], out_valid, out_result, out_id, out_ovf, exps[i], ovfs[i]);
            end
        end
        drive_req1(1'b0, 8'h00, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || busy_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL corner_drain got v=%b busy=%0d exp 0 6", out_valid, busy_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive_req0(1'b1, 8'h55, 1'b0);
        tick();
        drive_req0(1'b0, 8'h00, 1'b0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 8'h55) begin
            miscompares++;
            $display("FAIL mid_fill got v=%b r=%h exp 1 55", out_valid, out_result);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy_cnt !== 8'd0 || out_result !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_reset got v=%b busy=%0d r=%h exp 0 0 00", out_valid, busy_cnt, out_result);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic [9:0] got;
        logic [9:0] exp;
        out_ready = 1'b1;
        drive_req0(1'b1, 8'h10, 1'b0);
        drive_req1(1'b1, 8'h20, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL cont_grant_%0d got %b%b exp %b%b", k, req0_ready, req1_ready,
                         (k % 2 == 0), (k % 2 == 1));
            end
            if (k % 2 == 0) exp_q.push_back({1'b0, 1'b0, 8'h10});
            else            exp_q.push_back({1'b1, 1'b0, 8'hE0});
            tick();
            exp = exp_q.pop_front();
            got = {out_id, out_ovf, out_result};
            vectors++;
            if (out_valid !== 1'b1 || got !== exp) begin
                miscompares++;
                $display("FAIL cont_result_%0d got v=%b %h exp 1 %h", k, out_valid, got, exp);
            end
        end
        drive_req0(1'b0, 8'h00, 1'b0);
        drive_req1(1'b0, 8'h00, 1'b0);
        tick();
        vectors++;
        if (busy_cnt !== 8'd4 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL cont_busy got busy=%0d v=%b exp 4 0", busy_cnt, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive_req0(1'b1, 8'h10, 1'b0);
        drive_req1(1'b1, 8'h20, 1'b1);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || out_valid !== 1'b1 ||
                out_result !== 8'h10 || out_id !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d got rdy=%b%b v=%b r=%h id=%b exp 00 1 10 0",
                         k, req0_ready, req1_ready, out_valid, out_result, out_id);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready got %b%b exp 01", req0_ready, req1_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 8'hE0 || out_id !== 1'b1 || busy_cnt !== 8'd5) begin
            miscompares++;
            $display("FAIL bp_refill got v=%b r=%h id=%b busy=%0d exp 1 e0 1 5",
                     out_valid, out_result, out_id, busy_cnt);
        end
        drive_req0(1'b0, 8'h00, 1'b0);
        drive_req1(1'b0, 8'h00, 1'b0);
        tick();
        vectors++;
        if (out_valid !== 1'b0 || busy_cnt !== 8'd6) begin
            miscompares++;
            $display("FAIL bp_drain got v=%b busy=%0d exp 0 6", out_valid, busy_cnt);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        out_ready = 1'b1;
        drive_req0(1'b1, 8'h01, 1'b1);
        tick();
        for (int i = 1; i <= 256; i++) begin
            drive_req0(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            tick();
            if (i == 255) begin
                vectors++;
                if (busy_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL wrap_255 got %0d exp 255", busy_cnt);
                end
            end
        end
        vectors++;
        if (busy_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_0 got %0d exp 0", busy_cnt);
        end
        drive_req0(1'b0, 8'h00, 1'b0);
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_corners();
        test_reset_midstream();
        test_contention();
        test_backpressure();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
